// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared types and constants for the AXI read-channel grant controller
// Falls back to a 4-bit burst length when the shared AXI defines are not in the compile.
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

package axi_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_state_e;

    typedef logic mst_idx_t;

    localparam mst_idx_t MST_M0   = 1'b0;
    localparam mst_idx_t MST_M1   = 1'b1;
    localparam mst_idx_t RST_PRIO = MST_M0;

    localparam int LEN_W = `AXI_LEN_BITS;

    function automatic logic [1:0] idx_to_onehot(input mst_idx_t idx);
        return (idx == MST_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-requester round-robin selector
// A lone requester always wins; on contention the pointer picks the winner.
module rr_pick2
    import axi_rd_pkg::*;
(
    input  logic [1:0] req_i,
    input  mst_idx_t   ptr_i,
    output logic [1:0] gnt_o,
    output logic       vld_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = idx_to_onehot(ptr_i);
            default: gnt_o = 2'b00;
        endcase
    end

    assign vld_o = |req_i;

endmodule

// File: rtl/axi_rd_grant_ctrl.sv
// rtl/axi_rd_grant_ctrl.sv - AR/R path grant controller for two read masters (M0 fetch, M1 data)
// Optional stalled-burst release is compiled in with AXI_RD_TIMEOUT_EN.
module axi_rd_grant_ctrl
    import axi_rd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_CNT_W    = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     ARVALID_M0,
    input  logic                     ARVALID_M1,
    input  logic                     ARREADY_SEL,
    input  logic [`AXI_LEN_BITS-1:0] ARLEN_SEL,
    input  logic                     RVALID_SEL,
    input  logic                     RREADY_SEL,
    input  logic                     RLAST_SEL,
    output logic                     GNT_M0,
    output logic                     GNT_M1,
    output logic                     AR_PHASE,
    output logic                     BUSY,
    output logic [`AXI_LEN_BITS-1:0] BEAT_CNT,
    output logic                     LEN_ERR,
    output logic                     TIMEOUT_ERR
);

    if (2 ** TO_CNT_W <= TIMEOUT_CYC) begin : g_bad_to_cfg
        $error("TO_CNT_W is too narrow to hold TIMEOUT_CYC");
    end

    rd_state_e          state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               ar_phase_q, ar_phase_d;
    logic               busy_q, busy_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               len_err_q, len_err_d;
    logic               len_flag_q, len_flag_d;
    mst_idx_t           ptr_q, ptr_d;

    logic [1:0]         pick_gnt;
    logic               pick_vld;
    logic               arvalid_sel;
    logic               r_hs;
    logic [LEN_W-1:0]   beat_inc;

`ifdef AXI_RD_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYC - 1);
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic                to_err_q, to_err_d;
`endif

    rr_pick2 u_pick (
        .req_i ({ARVALID_M1, ARVALID_M0}),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .vld_o (pick_vld)
    );

    assign arvalid_sel = gnt_q[1] ? ARVALID_M1 : ARVALID_M0;
    assign r_hs        = RVALID_SEL & RREADY_SEL;
    assign beat_inc    = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ar_phase_d = ar_phase_q;
        busy_d     = busy_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        len_err_d  = 1'b0;
        len_flag_d = len_flag_q;
        ptr_d      = ptr_q;
`ifdef AXI_RD_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        to_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d      = pick_gnt;
                    ar_phase_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                // A dropped ARVALID keeps the grant; only a real handshake advances.
                if (arvalid_sel && ARREADY_SEL) begin
                    len_d      = ARLEN_SEL;
                    beat_cnt_d = '0;
                    ar_phase_d = 1'b0;
                    len_flag_d = 1'b0;
                    state_d    = DATA;
`ifdef AXI_RD_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                end
            end
            DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_inc;
                    if (RLAST_SEL) begin
                        len_err_d = (beat_cnt_q != len_q);
                        state_d   = IDLE;
                        gnt_d     = 2'b00;
                        busy_d    = 1'b0;
                        ptr_d     = gnt_q[1] ? MST_M0 : MST_M1;
                    end else if ((beat_cnt_q == len_q) && !len_flag_q) begin
                        // Overrun is reported once per burst even if the count saturates.
                        len_err_d  = 1'b1;
                        len_flag_d = 1'b1;
                    end
                end
`ifdef AXI_RD_TIMEOUT_EN
                if (r_hs) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LIMIT) begin
                    to_err_d = 1'b1;
                    state_d  = IDLE;
                    gnt_d    = 2'b00;
                    busy_d   = 1'b0;
                    ptr_d    = gnt_q[1] ? MST_M0 : MST_M1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = 2'b00;
                ar_phase_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            ar_phase_q <= 1'b0;
            busy_q     <= 1'b0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            len_err_q  <= 1'b0;
            len_flag_q <= 1'b0;
            ptr_q      <= RST_PRIO;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ar_phase_q <= ar_phase_d;
            busy_q     <= busy_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            len_err_q  <= len_err_d;
            len_flag_q <= len_flag_d;
            ptr_q      <= ptr_d;
        end
    end

`ifdef AXI_RD_TIMEOUT_EN
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign TIMEOUT_ERR = to_err_q;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    assign GNT_M0   = gnt_q[0];
    assign GNT_M1   = gnt_q[1];
    assign AR_PHASE = ar_phase_q;
    assign BUSY     = busy_q;
    assign BEAT_CNT = beat_cnt_q;
    assign LEN_ERR  = len_err_q;

endmodule

// File: tb/tb_axi_rd_grant_ctrl.sv
// tb/tb_axi_rd_grant_ctrl.sv - self-checking bench for axi_rd_grant_ctrl (AXI_RD_TIMEOUT_EN optional)
module tb_axi_rd_grant_ctrl;

    logic                     ACLK = 1'b0;
    logic                     ARESETn = 1'b0;
    logic [1:0]               arv = 2'b00;
    logic                     ARREADY_SEL = 1'b0;
    logic [`AXI_LEN_BITS-1:0] ARLEN_SEL = '0;
    logic                     RVALID_SEL = 1'b0;
    logic                     RREADY_SEL = 1'b0;
    logic                     RLAST_SEL = 1'b0;
    logic                     GNT_M0, GNT_M1, AR_PHASE, BUSY, LEN_ERR, TIMEOUT_ERR;
    logic [`AXI_LEN_BITS-1:0] BEAT_CNT;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[$];
    logic prev_gnt = 1'b0;

    always #5 ACLK = ~ACLK;

    axi_rd_grant_ctrl #(.TIMEOUT_CYC(8), .TO_CNT_W(8)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .ARVALID_M0  (arv[0]),
        .ARVALID_M1  (arv[1]),
        .ARREADY_SEL (ARREADY_SEL),
        .ARLEN_SEL   (ARLEN_SEL),
        .RVALID_SEL  (RVALID_SEL),
        .RREADY_SEL  (RREADY_SEL),
        .RLAST_SEL   (RLAST_SEL),
        .GNT_M0      (GNT_M0),
        .GNT_M1      (GNT_M1),
        .AR_PHASE    (AR_PHASE),
        .BUSY        (BUSY),
        .BEAT_CNT    (BEAT_CNT),
        .LEN_ERR     (LEN_ERR),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(negedge ACLK);
    endtask

    // Grant scoreboard: every new grant must match the oldest expected master.
    always @(negedge ACLK) begin
        if ((GNT_M0 | GNT_M1) && !prev_gnt) begin
            if (exp_q.size() == 0) begin
                check("gnt_unexpected", 32'(GNT_M1), 32'hdead);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("gnt_order", 32'(GNT_M1), 32'(e));
            end
        end
        check("gnt_excl", 32'(GNT_M0 & GNT_M1), 32'd0);
        prev_gnt = GNT_M0 | GNT_M1;
    end

    task automatic req_grant(input int m, input bit other);
        arv[m] = 1'b1;
        if (other) arv[1-m] = 1'b1;
        exp_q.push_back(m);
        tick();
        check("gnt_latency", 32'(m ? GNT_M1 : GNT_M0), 32'd1);
        check("ar_phase_on", 32'(AR_PHASE), 32'd1);
        check("busy_on", 32'(BUSY), 32'd1);
    endtask

    task automatic addr_hs(input int m, input int len);
        ARREADY_SEL = 1'b1;
        ARLEN_SEL   = `AXI_LEN_BITS'(len);
        tick();
        ARREADY_SEL = 1'b0;
        arv[m]      = 1'b0;
        check("ar_phase_off", 32'(AR_PHASE), 32'd0);
        check("beat_cnt_clr", 32'(BEAT_CNT), 32'd0);
        check("gnt_hold_data", 32'(m ? GNT_M1 : GNT_M0), 32'd1);
    endtask

    task automatic beats(input int n, input logic [7:0] err_mask, input bit do_last);
        for (int i = 0; i < n; i++) begin
            RVALID_SEL = 1'b1;
            RREADY_SEL = 1'b1;
            RLAST_SEL  = do_last && (i == n - 1);
            tick();
            check("beat_cnt", 32'(BEAT_CNT), 32'(i + 1));
            check("len_err", 32'(LEN_ERR), 32'(err_mask[i]));
        end
        RVALID_SEL = 1'b0;
        RREADY_SEL = 1'b0;
        RLAST_SEL  = 1'b0;
        if (do_last) begin
            check("busy_rel", 32'(BUSY), 32'd0);
            check("gnt_rel", 32'(GNT_M0 | GNT_M1), 32'd0);
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_gnt", 32'({GNT_M1, GNT_M0}), 32'd0);
        check("rst_ar_phase", 32'(AR_PHASE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_beat_cnt", 32'(BEAT_CNT), 32'd0);
        check("rst_len_err", 32'(LEN_ERR), 32'd0);
        check("rst_to_err", 32'(TIMEOUT_ERR), 32'd0);
        ARESETn = 1'b1;

        // Contention from reset: M0, M1, M0 with one IDLE cycle between grants.
        req_grant(0, 1'b1); addr_hs(0, 0); beats(1, 8'h00, 1'b1);
        req_grant(1, 1'b1); addr_hs(1, 0); beats(1, 8'h00, 1'b1);
        req_grant(0, 1'b1); addr_hs(0, 0); beats(1, 8'h00, 1'b1);
        arv = 2'b00;
        tick();
        check("idle_quiet", 32'(BUSY), 32'd0);

        // Four-beat burst, ARLEN=3, no length error.
        req_grant(0, 1'b0); addr_hs(0, 3); beats(4, 8'h00, 1'b1);

        // M1 stuck in ADDR while M0 requests.
        req_grant(1, 1'b0);
        arv[0] = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            check("stall_gnt_m1", 32'(GNT_M1), 32'd1);
            check("stall_gnt_m0", 32'(GNT_M0), 32'd0);
            check("stall_ar_phase", 32'(AR_PHASE), 32'd1);
        end
        addr_hs(1, 0); beats(1, 8'h00, 1'b1);

        // Short burst: ARLEN=1 but RLAST on the first beat.
        req_grant(0, 1'b0); addr_hs(0, 1); beats(1, 8'h01, 1'b1);

        // Overrun: ARLEN=1, RLAST on the third beat.
        req_grant(0, 1'b0); addr_hs(0, 1); beats(3, 8'h06, 1'b1);

        // Asynchronous reset in the middle of an M1 burst; pointer favoured M1 before it.
        req_grant(1, 1'b0); addr_hs(1, 3); beats(2, 8'h00, 1'b0);
        #2;
        ARESETn = 1'b0;
        arv     = 2'b11;
        #1;
        check("arst_gnt", 32'({GNT_M1, GNT_M0}), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        check("arst_beat_cnt", 32'(BEAT_CNT), 32'd0);
        check("arst_ar_phase", 32'(AR_PHASE), 32'd0);
        tick();
        ARESETn = 1'b1;
        req_grant(0, 1'b1); addr_hs(0, 0); beats(1, 8'h00, 1'b1);
        req_grant(1, 1'b0); addr_hs(1, 0); beats(1, 8'h00, 1'b1);

        // Stalled DATA phase with M1 waiting.
        req_grant(0, 1'b1); addr_hs(0, 0);
`ifdef AXI_RD_TIMEOUT_EN
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("to_err", 32'(TIMEOUT_ERR), 32'(t == 8));
            check("to_gnt_m0", 32'(GNT_M0), 32'(t != 8));
        end
        RVALID_SEL = 1'b1;
        RREADY_SEL = 1'b1;
        RLAST_SEL  = 1'b1;
        req_grant(1, 1'b0);
        RVALID_SEL = 1'b0;
        RREADY_SEL = 1'b0;
        RLAST_SEL  = 1'b0;
        check("late_rlast_ignored", 32'(LEN_ERR), 32'd0);
        addr_hs(1, 0); beats(1, 8'h00, 1'b1);
`else
        for (int t = 0; t < 20; t++) begin
            tick();
            check("hold_gnt_m0", 32'(GNT_M0), 32'd1);
            check("no_to_err", 32'(TIMEOUT_ERR), 32'd0);
        end
        beats(1, 8'h00, 1'b1);
        req_grant(1, 1'b0); addr_hs(1, 0); beats(1, 8'h00, 1'b1);
`endif
        tick();
        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
